// File: rtl/qsort_pkg.sv
// Shared types, sizes and the power-on contents of the 16-byte array for
// the in-place quicksort accelerator.
package qsort_pkg;

    localparam int N         = 16;
    localparam int DATA_W    = 8;
    localparam int IDX_W     = 5;
    localparam int CH_ADDR_W = 7;

    typedef logic signed [IDX_W-1:0]  idx_t;
    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_SCAN,
        ST_PIVOT,
        ST_DONE
    } qsort_state_e;

    function automatic data_t init_byte(input logic [3:0] k);
        case (k)
            4'd0:    return 8'sd23;
            4'd1:    return -8'sd5;
            4'd2:    return 8'sd100;
            4'd3:    return 8'sh80;
            4'd4:    return 8'sd0;
            4'd5:    return 8'sd127;
            4'd6:    return -8'sd77;
            4'd7:    return 8'sd42;
            4'd8:    return 8'sd7;
            4'd9:    return -8'sd1;
            4'd10:   return 8'sd55;
            4'd11:   return 8'sd7;
            4'd12:   return -8'sd30;
            4'd13:   return 8'sd88;
            4'd14:   return 8'sd3;
            default: return -8'sd64;
        endcase
    endfunction

endpackage

// File: rtl/qsort_stack.sv
// LIFO of (lo,hi) partition ranges, depth 16. A second entry can be pushed in
// the same cycle (push2); entries that do not fit are dropped.
module qsort_stack
    import qsort_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic push2,
    input  logic pop,
    input  idx_t lo_a,
    input  idx_t hi_a,
    input  idx_t lo_b,
    input  idx_t hi_b,
    output idx_t top_lo,
    output idx_t top_hi,
    output logic empty
);

    idx_t       lo_mem [N];
    idx_t       hi_mem [N];
    logic [4:0] cnt;
    logic [4:0] n_acc;
    logic [3:0] top_idx;
    logic [3:0] next_idx;

    // cnt==16 wraps top_idx to 15, which is the correct top slot
    assign top_idx  = cnt[3:0] - 4'd1;
    assign next_idx = cnt[3:0] + 4'd1;
    assign empty    = (cnt == 5'd0);
    assign top_lo   = lo_mem[top_idx];
    assign top_hi   = hi_mem[top_idx];

    always_comb begin
        n_acc = 5'd0;
        if (push && cnt != 5'd16) begin
            n_acc = (push2 && cnt != 5'd15) ? 5'd2 : 5'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && cnt != 5'd16) begin
            lo_mem[cnt[3:0]] <= lo_a;
            hi_mem[cnt[3:0]] <= hi_a;
        end
        if (push && push2 && cnt < 5'd15) begin
            lo_mem[next_idx] <= lo_b;
            hi_mem[next_idx] <= hi_b;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (pop && !empty) begin
            cnt <= cnt - 5'd1;
        end else begin
            cnt <= cnt + n_acc;
        end
    end

endmodule

// File: rtl/hls_quicksort_main.sv
// Iterative Lomuto quicksort over a 16-entry signed byte array held in flops.
// Host byte access through the slave port is built only with SLAVE_PORT_EN.
module hls_quicksort_main
    import qsort_pkg::*;
#(
    parameter int MEM_var_28860_28869 = 32,
    parameter int MEM_var_29121_28866 = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic [1:0]  S_oe_ram,
    input  logic [1:0]  S_we_ram,
    input  logic [13:0] S_addr_ram,
    input  logic [15:0] S_Wdata_ram,
    input  logic [7:0]  S_data_ram_size,
    input  logic [15:0] M_Rdata_ram,
    input  logic [1:0]  M_DataRdy,
    output logic        done_port,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy,
    output logic [1:0]  Mout_oe_ram,
    output logic [1:0]  Mout_we_ram,
    output logic [13:0] Mout_addr_ram,
    output logic [15:0] Mout_Wdata_ram,
    output logic [7:0]  Mout_data_ram_size
);

    qsort_state_e state_q, state_d;
    data_t        mem [N];
    idx_t         lo_q, hi_q, i_q, j_q;
    data_t        pivot_q;
    logic         scan_less;
    logic         swap_en;
    logic [3:0]   swap_x, swap_y;

    logic st_push, st_push2, st_pop, st_empty;
    idx_t st_lo_a, st_hi_a, st_lo_b, st_hi_b, st_top_lo, st_top_hi;

    qsort_stack u_stack (
        .clock  (clock),
        .reset  (reset),
        .push   (st_push),
        .push2  (st_push2),
        .pop    (st_pop),
        .lo_a   (st_lo_a),
        .hi_a   (st_hi_a),
        .lo_b   (st_lo_b),
        .hi_b   (st_hi_b),
        .top_lo (st_top_lo),
        .top_hi (st_top_hi),
        .empty  (st_empty)
    );

    assign scan_less = mem[j_q[3:0]] < pivot_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        st_push   = 1'b0;
        st_push2  = 1'b0;
        st_pop    = 1'b0;
        st_lo_a   = lo_q;
        st_hi_a   = hi_q;
        st_lo_b   = lo_q;
        st_hi_b   = hi_q;
        swap_en   = 1'b0;
        swap_x    = i_q[3:0];
        swap_y    = j_q[3:0];
        done_port = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_port) begin
                    st_push = 1'b1;
                    st_lo_a = '0;
                    st_hi_a = idx_t'(N - 1);
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                if (st_empty) begin
                    state_d = ST_DONE;
                end else begin
                    st_pop  = 1'b1;
                    state_d = (st_top_lo >= st_top_hi) ? ST_POP : ST_SCAN;
                end
            end
            ST_SCAN: begin
                swap_en = scan_less;
                if (j_q + 5'sd1 == hi_q) state_d = ST_PIVOT;
            end
            ST_PIVOT: begin
                swap_en  = 1'b1;
                swap_y   = hi_q[3:0];
                st_push  = 1'b1;
                st_push2 = 1'b1;
                st_lo_a  = lo_q;
                st_hi_a  = i_q - 5'sd1;
                // i==15 would wrap i+1 to -16; (hi,hi) is the same empty range
                st_lo_b  = (i_q == hi_q) ? hi_q : i_q + 5'sd1;
                st_hi_b  = hi_q;
                state_d  = ST_POP;
            end
            ST_DONE: begin
                done_port = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lo_q    <= '0;
            hi_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            pivot_q <= '0;
        end else begin
            case (state_q)
                ST_POP: begin
                    if (!st_empty) begin
                        lo_q    <= st_top_lo;
                        hi_q    <= st_top_hi;
                        i_q     <= st_top_lo;
                        j_q     <= st_top_lo;
                        pivot_q <= mem[st_top_hi[3:0]];
                    end
                end
                ST_SCAN: begin
                    j_q <= j_q + 5'sd1;
                    if (scan_less) i_q <= i_q + 5'sd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SLAVE_PORT_EN
    localparam logic [CH_ADDR_W-1:0] BASE = CH_ADDR_W'(MEM_var_28860_28869);

    logic [CH_ADDR_W-1:0] ch_addr [2];
    logic [CH_ADDR_W-1:0] ch_rel  [2];
    data_t                ch_wdata[2];
    data_t                rdata_q [2];
    logic [1:0]           ch_hit, ch_wr, rdy_q;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ch_addr[c]  = S_addr_ram[c*CH_ADDR_W +: CH_ADDR_W];
            ch_rel[c]   = ch_addr[c] - BASE;
            ch_hit[c]   = (ch_addr[c] >= BASE) && (ch_rel[c] < CH_ADDR_W'(N));
            ch_wdata[c] = S_Wdata_ram[c*DATA_W +: DATA_W];
            // writes during a sort are acknowledged but never land
            ch_wr[c]    = ch_hit[c] && S_we_ram[c] && (state_q == ST_IDLE)
                          && (S_data_ram_size[c*4 +: 4] == 4'd8);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdy_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                rdy_q[c]   <= ch_hit[c] && (S_oe_ram[c] || S_we_ram[c]);
                rdata_q[c] <= (ch_hit[c] && S_oe_ram[c]) ? mem[ch_rel[c][3:0]] : '0;
            end
        end
    end

    assign Sout_DataRdy   = rdy_q;
    assign Sout_Rdata_ram = {rdata_q[1], rdata_q[0]};

    logic unused_inputs;
    assign unused_inputs = ^{M_Rdata_ram, M_DataRdy, (MEM_var_29121_28866 != 0)};
`else
    assign Sout_DataRdy   = '0;
    assign Sout_Rdata_ram = '0;

    logic unused_inputs;
    assign unused_inputs = ^{M_Rdata_ram, M_DataRdy, S_oe_ram, S_we_ram, S_addr_ram,
                             S_Wdata_ram, S_data_ram_size, (MEM_var_29121_28866 != 0)};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) mem[k] <= init_byte(4'(k));
        end else begin
            if (swap_en) begin
                mem[swap_x] <= mem[swap_y];
                mem[swap_y] <= mem[swap_x];
            end
`ifdef SLAVE_PORT_EN
            // channel1 is applied last so it wins a same-byte collision
            for (int c = 0; c < 2; c++) begin
                if (ch_wr[c]) mem[ch_rel[c][3:0]] <= ch_wdata[c];
            end
`endif
        end
    end

    assign Mout_oe_ram        = '0;
    assign Mout_we_ram        = '0;
    assign Mout_addr_ram      = '0;
    assign Mout_Wdata_ram     = '0;
    assign Mout_data_ram_size = '0;

endmodule

// File: tb/tb_hls_quicksort_main.sv
// Directed bench for hls_quicksort_main: reset state, sort results and latency,
// restart/abort behaviour, and slave-port access when SLAVE_PORT_EN is set.
module tb_hls_quicksort_main;
    import qsort_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_port = 1'b0;
    logic [1:0]  S_oe_ram = '0;
    logic [1:0]  S_we_ram = '0;
    logic [13:0] S_addr_ram = '0;
    logic [15:0] S_Wdata_ram = '0;
    logic [7:0]  S_data_ram_size = '0;
    logic [15:0] M_Rdata_ram = '0;
    logic [1:0]  M_DataRdy = '0;
    logic        done_port;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic [1:0]  Mout_oe_ram, Mout_we_ram;
    logic [13:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    int total = 0;
    int bad   = 0;

    logic signed [7:0] init_tab [16] = '{8'sd23, -8'sd5, 8'sd100, 8'sh80, 8'sd0, 8'sd127,
        -8'sd77, 8'sd42, 8'sd7, -8'sd1, 8'sd55, 8'sd7, -8'sd30, 8'sd88, 8'sd3, -8'sd64};
    logic signed [7:0] sorted_tab [16] = '{8'sh80, -8'sd77, -8'sd64, -8'sd30, -8'sd5, -8'sd1,
        8'sd0, 8'sd3, 8'sd7, 8'sd7, 8'sd23, 8'sd42, 8'sd55, 8'sd88, 8'sd100, 8'sd127};
    logic signed [7:0] m_a [16];

    hls_quicksort_main dut (
        .clock              (clock),
        .reset              (reset),
        .start_port         (start_port),
        .S_oe_ram           (S_oe_ram),
        .S_we_ram           (S_we_ram),
        .S_addr_ram         (S_addr_ram),
        .S_Wdata_ram        (S_Wdata_ram),
        .S_data_ram_size    (S_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy),
        .done_port          (done_port),
        .Sout_Rdata_ram     (Sout_Rdata_ram),
        .Sout_DataRdy       (Sout_DataRdy),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference quicksort on m_a; returns busy cycles from the first POP to DONE.
    task automatic model_sort(output int cyc);
        int slo[$];
        int shi[$];
        int lo, hi, i, piv;
        logic signed [7:0] t;
        cyc = 0;
        slo.push_back(0);
        shi.push_back(15);
        while (1) begin
            cyc++;
            if (slo.size() == 0) break;
            lo = slo.pop_back();
            hi = shi.pop_back();
            if (lo >= hi) continue;
            piv = m_a[hi];
            i = lo;
            for (int j = lo; j < hi; j++) begin
                cyc++;
                if (m_a[j] < piv) begin
                    t = m_a[i]; m_a[i] = m_a[j]; m_a[j] = t;
                    i++;
                end
            end
            cyc++;
            t = m_a[i]; m_a[i] = m_a[hi]; m_a[hi] = t;
            slo.push_back(lo);    shi.push_back(i - 1);
            slo.push_back(i + 1); shi.push_back(hi);
        end
    endtask

    task automatic do_sort(input int extra_at, output int cyc, output int pulses);
        bit seen;
        seen   = 1'b0;
        cyc    = 0;
        pulses = 0;
        @(negedge clock);
        start_port = 1'b1;
        @(posedge clock);
        #1 start_port = 1'b0;
        while (!seen && cyc < 600) begin
            @(posedge clock);
            #1;
            cyc++;
            start_port = (cyc == extra_at);
            if (done_port) begin
                seen = 1'b1;
                pulses++;
            end
        end
        start_port = 1'b0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (done_port) pulses++;
        end
        check("sort_finished", 32'(seen), 32'd1);
    endtask

    task automatic check_array(input string tag);
        for (int k = 0; k < 16; k++) check(tag, 32'(dut.mem[k]), 32'(m_a[k]));
    endtask

`ifdef SLAVE_PORT_EN
    task automatic s_write(input int ch, input int addr, input logic [7:0] d,
                           input logic [3:0] sz, output logic ack);
        logic [6:0] a7;
        a7 = addr[6:0];
        @(negedge clock);
        S_we_ram[ch] = 1'b1;
        S_addr_ram[ch*7 +: 7] = a7;
        S_Wdata_ram[ch*8 +: 8] = d;
        S_data_ram_size[ch*4 +: 4] = sz;
        @(posedge clock);
        @(negedge clock);
        ack = Sout_DataRdy[ch];
        S_we_ram = '0;
        S_addr_ram = '0;
        S_Wdata_ram = '0;
        S_data_ram_size = '0;
    endtask

    task automatic s_read(input int ch, input int addr, output logic [7:0] d,
                          output logic rdy, output logic pre_rdy);
        logic [6:0] a7;
        a7 = addr[6:0];
        @(negedge clock);
        S_oe_ram[ch] = 1'b1;
        S_addr_ram[ch*7 +: 7] = a7;
        #1 pre_rdy = Sout_DataRdy[ch];
        @(posedge clock);
        @(negedge clock);
        d   = Sout_Rdata_ram[ch*8 +: 8];
        rdy = Sout_DataRdy[ch];
        S_oe_ram = '0;
        S_addr_ram = '0;
    endtask
`endif

    int exp_cyc, cyc, pulses;
    logic [7:0] rd;
    logic rdy, pre, ack;

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_done", 32'(done_port), 32'd0);
        check("rst_sout_data", 32'(Sout_Rdata_ram), 32'd0);
        check("rst_sout_rdy", 32'(Sout_DataRdy), 32'd0);
        check("rst_mout", 32'({Mout_oe_ram, Mout_we_ram, Mout_addr_ram}), 32'd0);
        check("rst_mout_data", 32'({Mout_Wdata_ram, Mout_data_ram_size}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 16; k++) m_a[k] = init_tab[k];
        check_array("rst_array");

        // sort the power-on table
        model_sort(exp_cyc);
        do_sort(0, cyc, pulses);
        check("init_latency", 32'(cyc), 32'(exp_cyc));
        check("init_pulses", 32'(pulses), 32'd1);
        for (int k = 0; k < 16; k++) check("init_sorted", 32'(dut.mem[k]), 32'(sorted_tab[k]));
        check("idle_after", 32'(dut.state_q), 32'(ST_IDLE));

        // sorting an already sorted array
        model_sort(exp_cyc);
        do_sort(0, cyc, pulses);
        check("resort_latency", 32'(cyc), 32'(exp_cyc));
        check("resort_pulses", 32'(pulses), 32'd1);
        check_array("resort_array");

        // abort mid-scan with an asynchronous reset
        @(negedge clock);
        start_port = 1'b1;
        @(posedge clock);
        #1 start_port = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        check("abort_in_scan", 32'(dut.state_q), 32'(ST_SCAN));
        reset = 1'b0;
        #1;
        check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("abort_done", 32'(done_port), 32'd0);
        check("abort_sout", 32'({Sout_Rdata_ram, Sout_DataRdy}), 32'd0);
        for (int k = 0; k < 16; k++) m_a[k] = init_tab[k];
        check_array("abort_array");
        @(negedge clock);
        reset = 1'b1;

        // a second start while busy must not trigger another sort
        model_sort(exp_cyc);
        do_sort(10, cyc, pulses);
        check("busy_start_latency", 32'(cyc), 32'(exp_cyc));
        check("busy_start_pulses", 32'(pulses), 32'd1);
        check_array("busy_start_array");

`ifdef SLAVE_PORT_EN
        // reverse-ordered data via alternating channels
        for (int k = 0; k < 16; k++) begin
            s_write(k % 2, 32 + k, 8'(15 - k), 4'd8, ack);
            check("rev_wr_ack", 32'(ack), 32'd1);
            m_a[k] = 8'(15 - k);
        end
        model_sort(exp_cyc);
        do_sort(0, cyc, pulses);
        check("rev_latency", 32'(cyc), 32'(exp_cyc));
        check("rev_pulses", 32'(pulses), 32'd1);
        for (int k = 0; k < 16; k++) begin
            s_read(k % 2, 32 + k, rd, rdy, pre);
            check("rev_read", 32'(rd), 32'(k));
        end

        // all-equal data
        for (int k = 0; k < 16; k++) begin
            s_write(0, 32 + k, 8'h05, 4'd8, ack);
            m_a[k] = 8'sd5;
        end
        model_sort(exp_cyc);
        do_sort(0, cyc, pulses);
        check("eq_latency", 32'(cyc), 32'(exp_cyc));
        check("eq_pulses", 32'(pulses), 32'd1);
        for (int k = 0; k < 16; k++) begin
            s_read(1, 32 + k, rd, rdy, pre);
            check("eq_read", 32'(rd), 32'h05);
        end

        // extreme values
        s_write(0, 40, 8'h80, 4'd8, ack);
        s_write(1, 32, 8'h7F, 4'd8, ack);
        m_a[8] = 8'sh80;
        m_a[0] = 8'sd127;
        model_sort(exp_cyc);
        do_sort(0, cyc, pulses);
        check("ext_latency", 32'(cyc), 32'(exp_cyc));
        s_read(0, 32, rd, rdy, pre);
        check("ext_min", 32'(rd), 32'h80);
        s_read(1, 47, rd, rdy, pre);
        check("ext_max", 32'(rd), 32'h7F);

        // read timing and address decode
        s_read(0, 33, rd, rdy, pre);
        check("rd33_pre_rdy", 32'(pre), 32'd0);
        check("rd33_rdy", 32'(rdy), 32'd1);
        check("rd33_data", 32'(rd), 32'h05);
        s_read(1, 48, rd, rdy, pre);
        check("rd48_rdy", 32'(rdy), 32'd0);
        check("rd48_data", 32'(rd), 32'd0);

        // non-byte write is acknowledged but ignored
        s_write(0, 33, 8'h66, 4'd4, ack);
        check("sz4_ack", 32'(ack), 32'd1);
        s_read(0, 33, rd, rdy, pre);
        check("sz4_data", 32'(rd), 32'h05);

        // same-byte collision: channel1 wins
        @(negedge clock);
        S_we_ram = 2'b11;
        S_addr_ram = {7'd35, 7'd35};
        S_Wdata_ram = 16'h4221;
        S_data_ram_size = 8'h88;
        @(negedge clock);
        check("dual_ack", 32'(Sout_DataRdy), 32'd3);
        S_we_ram = '0;
        S_addr_ram = '0;
        S_Wdata_ram = '0;
        S_data_ram_size = '0;
        s_read(0, 35, rd, rdy, pre);
        check("dual_winner", 32'(rd), 32'h42);
`else
        // slave port absent: writes have no effect and nothing is acknowledged
        @(negedge clock);
        S_we_ram = 2'b11;
        S_oe_ram = 2'b11;
        S_addr_ram = {7'd33, 7'd32};
        S_Wdata_ram = 16'h1111;
        S_data_ram_size = 8'h88;
        @(negedge clock);
        check("noport_rdy", 32'(Sout_DataRdy), 32'd0);
        check("noport_data", 32'(Sout_Rdata_ram), 32'd0);
        S_we_ram = '0;
        S_oe_ram = '0;
        S_addr_ram = '0;
        S_Wdata_ram = '0;
        S_data_ram_size = '0;
        @(negedge clock);
        check_array("noport_array");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
